// File: rtl/uart_tx_arbiter_if.sv
// Requester/UART write-port bundle for uart_tx_arbiter.
//   master : client side + UART top (drives req/len/data/tx_full)
//   slave  : the arbiter (drives wr_uart/w_data/grant/data_ack/done/busy)
// Signals:
//   req      per-requester packet request (level)
//   len      packed packet lengths, requester i at [i*LEN_WIDTH +: LEN_WIDTH]
//   data     packed current byte per requester
//   tx_full  TX FIFO full from UART top
//   wr_uart  write strobe into TX FIFO
//   w_data   byte written into TX FIFO
//   grant    one-hot owner of the port
//   data_ack one-cycle pulse, owner's current byte was written
//   done     one-cycle pulse, owner's packet is complete
//   busy     arbiter is not idle
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DBIT_WIDTH = 8,
  parameter int LEN_WIDTH  = 8
);
  logic [NUM_REQ-1:0]            req;
  logic [NUM_REQ*LEN_WIDTH-1:0]  len;
  logic [NUM_REQ*DBIT_WIDTH-1:0] data;
  logic                          tx_full;
  logic                          wr_uart;
  logic [DBIT_WIDTH-1:0]         w_data;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            data_ack;
  logic [NUM_REQ-1:0]            done;
  logic                          busy;

  modport master (
    output req, len, data, tx_full,
    input  wr_uart, w_data, grant, data_ack, done, busy
  );

  modport slave (
    input  req, len, data, tx_full,
    output wr_uart, w_data, grant, data_ack, done, busy
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing one UART TX FIFO write port
// among NUM_REQ requesters. A granted requester keeps the port until all
// of its latched LEN bytes have been written; writes happen only while
// tx_full is low.
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low reset
//   bus  uart_tx_arbiter_if.slave (req/len/data/tx_full in,
//        wr_uart/w_data/grant/data_ack/done/busy out)
module uart_tx_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DBIT_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int IDX_WIDTH  = 2
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

  state_t                 state;
  logic [IDX_WIDTH-1:0]   grant_idx;
  logic [IDX_WIDTH-1:0]   rr_ptr;
  logic [NUM_REQ-1:0]     grant_q;
  logic [NUM_REQ-1:0]     done_q;
  logic [LEN_WIDTH-1:0]   cnt;

  logic [LEN_WIDTH-1:0]   len_arr  [NUM_REQ];
  logic [DBIT_WIDTH-1:0]  data_arr [NUM_REQ];

  logic                   sel_vld;
  logic [IDX_WIDTH-1:0]   sel_idx;
  logic [IDX_WIDTH-1:0]   cand;
  logic                   wr;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign len_arr[i]  = bus.len[i*LEN_WIDTH +: LEN_WIDTH];
    assign data_arr[i] = bus.data[i*DBIT_WIDTH +: DBIT_WIDTH];
  end

  // Scan from the lowest priority offset down to rr_ptr itself, so the
  // last hit (closest to rr_ptr) is the one that sticks.
  always_comb begin
    sel_vld = 1'b0;
    sel_idx = '0;
    cand    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = IDX_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (bus.req[cand]) begin
        sel_vld = 1'b1;
        sel_idx = cand;
      end
    end
  end

  assign wr           = (state == SEND) && !bus.tx_full;
  assign bus.wr_uart  = wr;
  assign bus.w_data   = (state == SEND) ? data_arr[grant_idx] : '0;
  assign bus.data_ack = wr ? grant_q : '0;
  assign bus.grant    = grant_q;
  assign bus.done     = done_q;
  assign bus.busy     = (state != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant_idx <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      cnt       <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_vld) begin
            grant_idx <= sel_idx;
            grant_q   <= NUM_REQ'(1) << sel_idx;
            cnt       <= len_arr[sel_idx];
            // Zero-length packet: skip SEND, still owe the requester a done.
            if (len_arr[sel_idx] == '0) begin
              state  <= DONE;
              done_q <= NUM_REQ'(1) << sel_idx;
            end else begin
              state  <= SEND;
            end
          end
        end
        SEND: begin
          if (wr) begin
            cnt <= cnt - LEN_WIDTH'(1);
            if (cnt == LEN_WIDTH'(1)) begin
              state  <= DONE;
              done_q <= grant_q;
            end
          end
        end
        DONE: begin
          done_q  <= '0;
          grant_q <= '0;
          state   <= IDLE;
          rr_ptr  <= (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                                                           : grant_idx + IDX_WIDTH'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table-driven vectors, directed
// multi-cycle sequences and randomized traffic against a packet-level model.
module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 8;
  localparam int LW = 8;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(N), .DBIT_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

  uart_tx_arbiter #(.NUM_REQ(N), .DBIT_WIDTH(DW), .LEN_WIDTH(LW), .IDX_WIDTH(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [N-1:0]  g;
    logic [N-1:0]  a;
    logic [N-1:0]  d;
    logic          w;
    logic [DW-1:0] wd;
    logic          b;
    logic          cw;   // whether w_data is checked this cycle
  } exp_t;

  typedef struct {
    logic [N-1:0]  req;
    logic [LW-1:0] len;
    logic          txf;
    logic [N-1:0]  eg;
    logic          ew;
    logic [DW-1:0] ewd;
    logic [N-1:0]  ed;
    logic          eb;
    logic          cw;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  logic [N-1:0]  req_s;
  logic [LW-1:0] len_s [N];
  logic          tx_full_s;
  int            tb_sent [N];

  logic [N-1:0]  smp_grant, smp_done;
  logic          smp_wr;

  // Packet-level reference: an owner with bytes left is sending, an owner
  // with none left is in its completion cycle, no owner means arbitration.
  int m_owner, m_left, m_ptr;
  int m_sent [N];

  exp_t zexp;

  function automatic logic [DW-1:0] byte_of(int i, int n);
    return DW'(129 + 16 * i + n);
  endfunction

  function automatic int onehot_idx(logic [N-1:0] v);
    int r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic vec_t mk(logic [N-1:0] req, logic [LW-1:0] len, logic txf,
                              logic [N-1:0] eg, logic ew, logic [DW-1:0] ewd,
                              logic [N-1:0] ed, logic eb, logic cw);
    vec_t v;
    v.req = req; v.len = len; v.txf = txf; v.eg = eg; v.ew = ew;
    v.ewd = ewd; v.ed = ed; v.eb = eb; v.cw = cw;
    return v;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_left  = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) begin
      m_sent[i]  = 0;
      tb_sent[i] = 0;
    end
  endtask

  task automatic model_step(output exp_t e);
    bit found;
    e = zexp;
    if (m_owner >= 0 && m_left > 0) begin
      e.b  = 1'b1;
      e.g  = N'(1) << m_owner;
      e.w  = !tx_full_s;
      e.wd = byte_of(m_owner, m_sent[m_owner]);
      if (e.w) begin
        e.a = e.g;
        m_sent[m_owner]++;
        m_left--;
      end
    end else if (m_owner >= 0) begin
      e.b  = 1'b1;
      e.g  = N'(1) << m_owner;
      e.d  = e.g;
      e.cw = 1'b0;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
    end else begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        int p;
        p = (m_ptr + k) % N;
        if (!found && req_s[p]) begin
          found   = 1'b1;
          m_owner = p;
          m_left  = int'(len_s[p]);
        end
      end
    end
  endtask

  task automatic drive();
    bus.req     = req_s;
    bus.tx_full = tx_full_s;
    for (int i = 0; i < N; i++) begin
      bus.len[i*LW +: LW]  = len_s[i];
      bus.data[i*DW +: DW] = byte_of(i, tb_sent[i]);
    end
  endtask

  task automatic compare(input string tag, input exp_t e);
    bit ok;
    ok = (bus.grant === e.g) && (bus.done === e.d) && (bus.wr_uart === e.w) &&
         (bus.data_ack === e.a) && (bus.busy === e.b) &&
         (!e.cw || (bus.w_data === e.wd));
    n_vec++;
    if (!ok) begin
      n_bad++;
      $display("FAIL %s t=%0t got grant=%b wr=%b wd=%h ack=%b done=%b busy=%b, want grant=%b wr=%b wd=%h(chk %0b) ack=%b done=%b busy=%b",
               tag, $time, bus.grant, bus.wr_uart, bus.w_data, bus.data_ack, bus.done, bus.busy,
               e.g, e.w, e.wd, e.cw, e.a, e.d, e.b);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", tag, got, want);
    end
  endtask

  // One clock cycle: drive at posedge+1, sample at negedge, return at posedge+1.
  task automatic run_cycle(input string tag, input bit use_row, input exp_t rexp);
    exp_t me;
    drive();
    @(negedge clk);
    model_step(me);
    compare(tag, use_row ? rexp : me);
    smp_grant = bus.grant;
    smp_done  = bus.done;
    smp_wr    = bus.wr_uart;
    for (int i = 0; i < N; i++) if (bus.data_ack[i]) tb_sent[i]++;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input string tag);
    rst       = 1'b0;
    req_s     = '0;
    tx_full_s = 1'b0;
    model_reset();
    drive();
    #1;
    compare(tag, zexp);
    @(posedge clk);
    #1;
    compare({tag, "_hold"}, zexp);
    rst = 1'b1;
  endtask

  task automatic set_len_all(input logic [LW-1:0] l);
    for (int i = 0; i < N; i++) len_s[i] = l;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    vec_t tbl [15];
    exp_t rexp;
    int   rr_idx [$];
    int   rr_cyc [$];
    int   exp_order [5];
    logic [N-1:0] prev_g, next_g;
    int   wr1, wrz;
    bit   seen;
    logic [N-1:0] d_at1, g_at;

    zexp = '{g: '0, a: '0, d: '0, w: 1'b0, wd: '0, b: 1'b0, cw: 1'b1};
    exp_order = '{0, 1, 2, 3, 0};
    smp_grant = '0; smp_done = '0; smp_wr = 1'b0;
    set_len_all('0);

    // single requester (rows 0-5), then backpressure (rows 6-14)
    tbl[0]  = mk(4'b0100, 8'd3, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1);
    tbl[1]  = mk(4'b0100, 8'd3, 1'b0, 4'b0100, 1'b1, 8'hA1, 4'b0000, 1'b1, 1'b1);
    tbl[2]  = mk(4'b0100, 8'd3, 1'b0, 4'b0100, 1'b1, 8'hA2, 4'b0000, 1'b1, 1'b1);
    tbl[3]  = mk(4'b0100, 8'd3, 1'b0, 4'b0100, 1'b1, 8'hA3, 4'b0000, 1'b1, 1'b1);
    tbl[4]  = mk(4'b0000, 8'd3, 1'b0, 4'b0100, 1'b0, 8'h00, 4'b0100, 1'b1, 1'b0);
    tbl[5]  = mk(4'b0000, 8'd3, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1);
    tbl[6]  = mk(4'b0001, 8'd2, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1);
    for (int r = 7; r <= 10; r++)
      tbl[r] = mk(4'b0001, 8'd2, 1'b1, 4'b0001, 1'b0, 8'h81, 4'b0000, 1'b1, 1'b1);
    tbl[11] = mk(4'b0001, 8'd2, 1'b0, 4'b0001, 1'b1, 8'h81, 4'b0000, 1'b1, 1'b1);
    tbl[12] = mk(4'b0001, 8'd2, 1'b0, 4'b0001, 1'b1, 8'h82, 4'b0000, 1'b1, 1'b1);
    tbl[13] = mk(4'b0000, 8'd2, 1'b0, 4'b0001, 1'b0, 8'h00, 4'b0001, 1'b1, 1'b0);
    tbl[14] = mk(4'b0000, 8'd2, 1'b0, 4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 1'b1);

    rst = 1'b1;
    req_s = '0; tx_full_s = 1'b0;
    model_reset();
    drive();
    #1;
    apply_reset("reset");
    @(posedge clk);
    #1;

    for (int r = 0; r < 15; r++) begin
      req_s = tbl[r].req;
      set_len_all(tbl[r].len);
      tx_full_s = tbl[r].txf;
      rexp.g = tbl[r].eg;   rexp.w = tbl[r].ew;  rexp.wd = tbl[r].ewd;
      rexp.a = tbl[r].ew ? tbl[r].eg : '0;
      rexp.d = tbl[r].ed;   rexp.b = tbl[r].eb;  rexp.cw = tbl[r].cw;
      run_cycle($sformatf("table[%0d]", r), 1'b1, rexp);
    end

    // round robin from rr_ptr=0
    apply_reset("reset2");
    set_len_all(8'd1);
    prev_g = '0;
    for (int c = 0; c < 16; c++) begin
      req_s = (c < 14) ? 4'hF : 4'h0;
      run_cycle("rr", 1'b0, zexp);
      if (smp_grant != '0 && prev_g == '0) begin
        rr_idx.push_back(onehot_idx(smp_grant));
        rr_cyc.push_back(c);
      end
      prev_g = smp_grant;
    end
    check_int("rr_count", rr_idx.size(), 5);
    for (int k = 0; k < 5 && k < rr_idx.size(); k++) begin
      check_int($sformatf("rr_order[%0d]", k), rr_idx[k], exp_order[k]);
      if (k > 0) check_int($sformatf("rr_spacing[%0d]", k), rr_cyc[k] - rr_cyc[k-1], 3);
    end

    // packet atomicity: requester 1 dropped, requester 0 raised mid-packet
    set_len_all(8'd4);
    wr1 = 0; seen = 1'b0; next_g = '0;
    for (int c = 0; c < 13; c++) begin
      req_s = (c < 2) ? 4'b0010 : ((c < 11) ? 4'b0001 : 4'b0000);
      run_cycle("atomic", 1'b0, zexp);
      if (smp_wr && smp_grant == 4'b0010) wr1++;
      if (seen && smp_grant != '0 && next_g == '0) next_g = smp_grant;
      if (smp_done == 4'b0010) seen = 1'b1;
    end
    check_int("atomic_bytes", wr1, 4);
    check_int("atomic_next_grant", int'(next_g), 1);

    // zero-length packet, then rr_ptr must have wrapped to 0
    set_len_all(8'd1);
    len_s[3] = 8'd0;
    wrz = 0; d_at1 = '0; g_at = '0;
    for (int c = 0; c < 6; c++) begin
      req_s = (c == 0) ? 4'b1000 : ((c < 3) ? 4'b1001 : 4'b0000);
      run_cycle("zero_len", 1'b0, zexp);
      if (c < 3 && smp_wr) wrz++;
      if (c == 1) d_at1 = smp_done;
      if (c == 3) g_at = smp_grant;
    end
    check_int("zero_len_writes", wrz, 0);
    check_int("zero_len_done", int'(d_at1), 8);
    check_int("zero_len_ptr_wrap", int'(g_at), 1);

    // move rr_ptr to 3, then reset asynchronously in the middle of a packet
    set_len_all(8'd1);
    for (int c = 0; c < 4; c++) begin
      req_s = (c == 0) ? 4'b0100 : 4'b0000;
      run_cycle("pre_rst", 1'b0, zexp);
    end
    set_len_all(8'd5);
    for (int c = 0; c < 3; c++) begin
      req_s = 4'b0100;
      run_cycle("pre_rst_send", 1'b0, zexp);
    end
    #2;
    apply_reset("async_rst");
    set_len_all(8'd2);
    g_at = '0;
    for (int c = 0; c < 5; c++) begin
      req_s = (c < 3) ? 4'b1010 : 4'b0000;
      run_cycle("post_rst", 1'b0, zexp);
      if (c == 1) g_at = smp_grant;
    end
    check_int("post_rst_grant", int'(g_at), 2);

    // maximum packet length
    set_len_all(8'd1);
    len_s[0] = 8'd255;
    wr1 = 0; seen = 1'b0;
    for (int c = 0; c < 300 && !seen; c++) begin
      req_s = (c == 0) ? 4'b0001 : 4'b0000;
      run_cycle("max_len", 1'b0, zexp);
      if (smp_wr && smp_grant == 4'b0001) wr1++;
      if (smp_done == 4'b0001) seen = 1'b1;
    end
    check_int("max_len_bytes", wr1, 255);
    check_int("max_len_done_seen", int'(seen), 1);

    // randomized traffic against the model
    for (int c = 0; c < 2000; c++) begin
      req_s = N'($urandom_range(0, (1 << N) - 1));
      for (int i = 0; i < N; i++) len_s[i] = LW'($urandom_range(0, 4));
      tx_full_s = ($urandom_range(0, 9) < 3);
      run_cycle("random", 1'b0, zexp);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin, packet-atomic arbiter that shares the single UART transmit write port (wr_uart / w_data / tx_full) among NUM_REQ requesters. Once a requester is granted, it owns the port until all of its LEN bytes have been written into the TX FIFO. The block sits between the client logic and the UART top-level write interface. It only writes into the FIFO when tx_full is low.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DBIT_WIDTH, 8, data byte width (matches UART data width)
LEN_WIDTH, 8, width of per-requester packet length field
IDX_WIDTH, 2, width of requester index, must equal clog2(NUM_REQ)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
req  input  NUM_REQ  per-requester packet request, level
len  input  NUM_REQ*LEN_WIDTH  packed packet lengths, requester i at bits [i*LEN_WIDTH +: LEN_WIDTH]
data  input  NUM_REQ*DBIT_WIDTH  packed current byte per requester
tx_full  input  1  TX FIFO full, from UART top
wr_uart  output  1  write strobe to TX FIFO
w_data  output  DBIT_WIDTH  byte to TX FIFO
grant  output  NUM_REQ  one-hot owner of the port, registered
data_ack  output  NUM_REQ  one-cycle pulse: the granted requester's current byte was written
done  output  NUM_REQ  one-cycle pulse: the granted requester's packet is complete
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, grant=0, done=0, cnt=0, rr_ptr=0. Combinational outputs evaluate to 0 in IDLE: wr_uart=0, w_data=0, data_ack=0, busy=0. Reset mid-packet abandons the packet with no done pulse; bytes already written stay in the FIFO.
- States: IDLE, SEND, DONE.
- IDLE, selection: select the first asserted req scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ. rr_ptr is the highest-priority index.
- IDLE, winner with len!=0: go to SEND next cycle; latch grant index and cnt=len.
- IDLE, winner with len==0: go directly to DONE, latch grant; no byte is written.
- IDLE, no req: stay in IDLE.
- SEND, write rule: wr_uart = ~tx_full (combinational); w_data = data[grant]; data_ack[grant] = wr_uart.
  - Each write decrements cnt.
  - A write with cnt==1 moves the FSM to DONE.
  - tx_full=1 stalls in SEND with no write and no ack.
- DONE (one cycle): done[grant]=1; rr_ptr <= grant_idx+1, wrapping NUM_REQ-1 -> 0; grant cleared; next state IDLE.
- grant is high from entry into SEND (or DONE for len==0) through the DONE cycle.
- Latency:
  - req high in IDLE at cycle 0 -> grant and first possible wr_uart at cycle 1.
  - Last write at cycle k -> done at cycle k+1 -> IDLE at k+2 -> next grant at k+3 earliest.
- Requester obligations:
  - Hold req, len and data stable while granted.
  - Present the next byte on the cycle after each data_ack.
- Changes while granted are ignored: req deasserted mid-packet, and len changes after latching, have no effect; the packet always completes.
- At most one wr_uart per cycle; never wr_uart while tx_full=1; never wr_uart outside SEND.
- cnt is LEN_WIDTH bits; len = 2^LEN_WIDTH-1 is the maximum packet length.

Test Plan:
- Single requester: req[2]=1, len[2]=3, bytes 0xA1,0xA2,0xA3, tx_full=0 -> grant=0100 at cycle 1; wr_uart on cycles 1–3 with w_data A1,A2,A3; done[2] at cycle 4; busy=0 at cycle 5.
- Round robin: req=1111, every len=1, rr_ptr=0 -> grant order 0,1,2,3,0; a new grant every 3 cycles; rr_ptr wraps 3->0.
- Backpressure: len[0]=2, tx_full high for cycles 1–4 -> no wr_uart and no data_ack during the stall; writes on cycles 5 and 6; done at cycle 7.
- Packet atomicity: req[1] packet with len=4 granted; req[0] asserted and req[1] dropped mid-packet -> all 4 bytes of requester 1 still sent; requester 0 is granted after done[1].
- Zero length: len[3]=0, req[3]=1 -> wr_uart never asserted; done[3] pulses at cycle 1; rr_ptr becomes 0.
- Async reset: drive rst=0 mid-SEND, between clock edges -> grant, wr_uart and busy go to 0 immediately; no done pulse; after release with req[1]=1, requester 1 is granted with rr_ptr=0 priority.
